// File: rtl/wb_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_slave_if
// Brief    : Wishbone classic bus bundle between the arbiter and RAM slave.
//            wb_err exists only when WB_RAM_SLAVE_ERR_EN is defined.
// Revision : 1.0
// ============================================================================
interface wb_ram_slave_if #(
  parameter int DW = 32
) ();
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [DW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack;
`ifdef WB_RAM_SLAVE_ERR_EN
  logic          wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack, wb_err
  );
  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack, wb_err
  );
`else
  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack
  );
  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack
  );
`endif
endinterface
`default_nettype wire

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_slave
// Brief    : Wishbone classic word RAM responder with WAIT_CYC wait states.
//            Define WB_RAM_SLAVE_ERR_EN to answer out-of-range with wb_err.
// Revision : 1.0
// ============================================================================
module wb_ram_slave #(
  parameter int            DW         = 32,
  parameter int            DEPTH_LOG2 = 10,
  parameter int            WAIT_CYC   = 1,
  parameter logic [DW-1:0] BASE_ADR   = 32'h0000_4000
) (
  input  logic          clk,
  input  logic          rst,
  wb_ram_slave_if.slave bus
);

  localparam int         c_depth = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_wait  = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_we;
  logic [DW-1:0]         r_dat;
  logic                  r_ok;
  logic                  r_ack;
  logic [DW-1:0]         r_dat_o;
  logic [DW-1:0]         r_mem [c_depth];

  logic                  w_req;
  logic                  w_in_idle;
  logic                  w_bus_ok;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_we;
  logic [DW-1:0]         w_dat;
  logic                  w_ok;
  logic                  w_enter_ack;
  logic                  w_unused_adr;

  assign w_req     = bus.wb_cyc & bus.wb_stb;
  assign w_in_idle = (r_state == ST_IDLE);

`ifdef WB_RAM_SLAVE_ERR_EN
  assign w_bus_ok = (bus.wb_adr[DW-1:DEPTH_LOG2+2] == BASE_ADR[DW-1:DEPTH_LOG2+2]);
`else
  assign w_bus_ok = 1'b1;
`endif

  // Low address bits are byte lanes; upper bits alias unless error reporting is on.
  assign w_unused_adr = ^{bus.wb_adr[1:0], bus.wb_adr[DW-1:DEPTH_LOG2+2]};

  // With zero wait states the access happens on the sampling edge itself,
  // so the live bus values stand in for the not-yet-latched copies.
  assign w_idx = w_in_idle ? bus.wb_adr[DEPTH_LOG2+1:2] : r_idx;
  assign w_we  = w_in_idle ? bus.wb_we                   : r_we;
  assign w_dat = w_in_idle ? bus.wb_dat_i                : r_dat;
  assign w_ok  = w_in_idle ? w_bus_ok                    : r_ok;

  // Gated by rst so nothing reaches the RAM while reset is held.
  assign w_enter_ack = rst & (w_state_nxt == ST_ACK);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_cnt_nxt   = c_wait;
          w_state_nxt = (c_wait != 4'd0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_dat   <= '0;
      r_ok    <= 1'b1;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_in_idle && w_req) begin
        r_idx <= bus.wb_adr[DEPTH_LOG2+1:2];
        r_we  <= bus.wb_we;
        r_dat <= bus.wb_dat_i;
        r_ok  <= w_bus_ok;
      end
      r_ack <= w_enter_ack & w_ok;
      if (w_enter_ack && w_ok && !w_we) begin
        r_dat_o <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_ack && w_ok && w_we) begin
      r_mem[w_idx] <= w_dat;
    end
  end

`ifdef WB_RAM_SLAVE_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_enter_ack & ~w_ok;
    end
  end

  assign bus.wb_err = r_err;
`endif

  assign bus.wb_ack   = r_ack;
  assign bus.wb_dat_o = r_dat_o;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ram_slave
// Brief    : Scoreboard bench for wb_ram_slave with 2, 0 and 3 wait states.
// Revision : 1.0
// ============================================================================
module tb_wb_ram_slave;

  typedef struct {
    int          cyc;
    bit          err;
    bit          chk_dat;
    logic [31:0] dat;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc_cnt = 0;
  int          checks = 0;
  int          passes = 0;
  int          sel = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  logic        m_cyc = 1'b0;
  logic        m_stb = 1'b0;
  logic        m_we  = 1'b0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;

  logic        mon_ack;
  logic        mon_err;
  logic [31:0] mon_dat;

  wb_ram_slave_if #(.DW(32)) bus_w2 ();
  wb_ram_slave_if #(.DW(32)) bus_w0 ();
  wb_ram_slave_if #(.DW(32)) bus_w3 ();

  assign bus_w2.wb_cyc = m_cyc;  assign bus_w0.wb_cyc = m_cyc;  assign bus_w3.wb_cyc = m_cyc;
  assign bus_w2.wb_stb = m_stb;  assign bus_w0.wb_stb = m_stb;  assign bus_w3.wb_stb = m_stb;
  assign bus_w2.wb_we  = m_we;   assign bus_w0.wb_we  = m_we;   assign bus_w3.wb_we  = m_we;
  assign bus_w2.wb_adr = m_adr;  assign bus_w0.wb_adr = m_adr;  assign bus_w3.wb_adr = m_adr;
  assign bus_w2.wb_dat_i = m_dat; assign bus_w0.wb_dat_i = m_dat; assign bus_w3.wb_dat_i = m_dat;

  wb_ram_slave #(.DW(32), .DEPTH_LOG2(10), .WAIT_CYC(2), .BASE_ADR(32'h0000_4000)) u_w2 (
    .clk(clk), .rst(rst), .bus(bus_w2));
  wb_ram_slave #(.DW(32), .DEPTH_LOG2(10), .WAIT_CYC(0), .BASE_ADR(32'h0000_4000)) u_w0 (
    .clk(clk), .rst(rst), .bus(bus_w0));
  wb_ram_slave #(.DW(32), .DEPTH_LOG2(10), .WAIT_CYC(3), .BASE_ADR(32'h0000_4000)) u_w3 (
    .clk(clk), .rst(rst), .bus(bus_w3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always_comb begin
    mon_ack = 1'b0;
    mon_err = 1'b0;
    mon_dat = '0;
    case (sel)
      0: begin mon_ack = bus_w2.wb_ack; mon_dat = bus_w2.wb_dat_o; end
      1: begin mon_ack = bus_w0.wb_ack; mon_dat = bus_w0.wb_dat_o; end
      default: begin mon_ack = bus_w3.wb_ack; mon_dat = bus_w3.wb_dat_o; end
    endcase
`ifdef WB_RAM_SLAVE_ERR_EN
    case (sel)
      0:       mon_err = bus_w2.wb_err;
      1:       mon_err = bus_w0.wb_err;
      default: mon_err = bus_w3.wb_err;
    endcase
`endif
  end

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Response monitor: every ack/err of the selected DUT must match the queue head.
  always @(negedge clk) begin
    if (rst && (mon_ack || mon_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1'b0, {30'd0, mon_err, mon_ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_lat"}, cyc_cnt == mon_e.cyc, 32'(cyc_cnt), 32'(mon_e.cyc));
        chk({mon_e.name, "_kind"}, {mon_err, mon_ack} == {mon_e.err, !mon_e.err},
            {30'd0, mon_err, mon_ack}, {30'd0, mon_e.err, !mon_e.err});
        if (mon_e.chk_dat)
          chk({mon_e.name, "_dat"}, mon_dat === mon_e.dat, mon_dat, mon_e.dat);
      end
    end
  end

  task automatic bus_idle();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0;
  endtask

  // stb_cyc == 0 holds the request until a response; otherwise drops after stb_cyc edges.
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input int w, input bit exp_err, input logic [31:0] exp_dat,
                      input int stb_cyc, input string name);
    bit got;
    exp_t e;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = dat;
    if (stb_cyc == 0) begin
      e.cyc = cyc_cnt + 1 + w; e.err = exp_err; e.chk_dat = (!we) || exp_err;
      e.dat = exp_dat; e.name = name;
      sb.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = mon_ack | mon_err;
      end
      if (!got) chk({name, "_timeout"}, 1'b0, 32'd0, 32'd1);
      @(posedge clk); #1;
    end else begin
      repeat (stb_cyc) @(posedge clk);
      #1;
    end
    bus_idle();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    logic any_ack;
    // Reset with a noisy bus
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      m_cyc = 1'($urandom); m_stb = 1'($urandom); m_we = 1'($urandom);
      m_adr = $urandom; m_dat = $urandom;
    end
    @(negedge clk);
    chk("rst_ack_w2", bus_w2.wb_ack == 1'b0, {31'd0, bus_w2.wb_ack}, 32'd0);
    chk("rst_dat_w2", bus_w2.wb_dat_o == 32'd0, bus_w2.wb_dat_o, 32'd0);
    chk("rst_ack_w0", bus_w0.wb_ack == 1'b0, {31'd0, bus_w0.wb_ack}, 32'd0);
    chk("rst_dat_w0", bus_w0.wb_dat_o == 32'd0, bus_w0.wb_dat_o, 32'd0);
    chk("rst_ack_w3", bus_w3.wb_ack == 1'b0, {31'd0, bus_w3.wb_ack}, 32'd0);
    chk("rst_dat_w3", bus_w3.wb_dat_o == 32'd0, bus_w3.wb_dat_o, 32'd0);
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b1;
    any_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_ack = any_ack | bus_w2.wb_ack | bus_w0.wb_ack | bus_w3.wb_ack;
    end
    chk("idle_no_ack", any_ack == 1'b0, {31'd0, any_ack}, 32'd0);

    // Two wait states
    sel = 0;
    xfer(1'b1, 32'h0000_4010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 0, "w2_wr");
    xfer(1'b0, 32'h0000_4010, 32'h0,         2, 1'b0, 32'hDEAD_BEEF, 0, "w2_rd");

    // Zero wait states, including the top word of the window
    sel = 1;
    xfer(1'b1, 32'h0000_4FFC, 32'h0BAD_F00D, 0, 1'b0, 32'h0, 0, "w0_wr_top");
    xfer(1'b1, 32'h0000_4000, 32'h1111_1111, 0, 1'b0, 32'h0, 0, "w0_wr_base");
    xfer(1'b0, 32'h0000_4000, 32'h0,         0, 1'b0, 32'h1111_1111, 0, "w0_rd_base");
    xfer(1'b0, 32'h0000_4FFC, 32'h0,         0, 1'b0, 32'h0BAD_F00D, 0, "w0_rd_top");

    // Out-of-range address
`ifdef WB_RAM_SLAVE_ERR_EN
    xfer(1'b0, 32'h0000_8000, 32'h0, 0, 1'b1, 32'h0BAD_F00D, 0, "w0_oor_err");
`else
    xfer(1'b0, 32'h0000_8000, 32'h0, 0, 1'b0, 32'h1111_1111, 0, "w0_oor_alias");
`endif

    // Three wait states: seed words, then an aborted write
    sel = 2;
    xfer(1'b1, 32'h0000_4020, 32'h1234_5678, 3, 1'b0, 32'h0, 0, "w3_wr_seed20");
    xfer(1'b1, 32'h0000_4030, 32'h5A5A_5A5A, 3, 1'b0, 32'h0, 0, "w3_wr_seed30");
    xfer(1'b1, 32'h0000_4020, 32'hCAFE_F00D, 3, 1'b0, 32'h0, 1, "w3_wr_abort");
    xfer(1'b0, 32'h0000_4020, 32'h0,         3, 1'b0, 32'h1234_5678, 0, "w3_rd_after_abort");

    // Reset pulse while a write sits in WAIT
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h0000_4030; m_dat = 32'hFFFF_0000;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 bus_idle();
    @(negedge clk);
    chk("midrst_ack", bus_w3.wb_ack == 1'b0, {31'd0, bus_w3.wb_ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    xfer(1'b0, 32'h0000_4030, 32'h0, 3, 1'b0, 32'h5A5A_5A5A, 0, "w3_rd_after_rst");

    repeat (5) @(posedge clk);
    chk("sb_drained", sb.size() == 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
